// File: rtl/fsm_control_multi.sv
// Control FSM for the flow-control datapath: threshold capture, IDLE/ACTIVE reporting,
// sticky per-FIFO overflow errors and a saturating count of error entries.
module fsm_control_multi #(
   parameter int NUM_FIFOS = 5,
   parameter int UMB_W     = 4,
   parameter int CNT_W     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       init,
   input  logic                       err_clear,
   input  logic [NUM_FIFOS*UMB_W-1:0] umbral_in,
   input  logic [NUM_FIFOS-1:0]       fifo_error,
   input  logic [NUM_FIFOS-1:0]       fifo_empty,
   output logic [NUM_FIFOS*UMB_W-1:0] umbrales_out,
   output logic [2:0]                 state_out,
   output logic                       idle_out,
   output logic                       active_out,
   output logic [NUM_FIFOS-1:0]       error_out,
   output logic [CNT_W-1:0]           error_cnt
);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state;
   state_t next_state;
   logic   any_err;
   logic   all_empty;

   assign any_err   = |fifo_error;
   assign all_empty = &fifo_empty;
   assign state_out = state;

   // Next-state decode; init overrides every legal state, illegal codes fall back to RESET.
   always_comb begin
      next_state = ST_RESET;
      case (state)
         ST_RESET: next_state = ST_INIT;
         ST_INIT: begin
            if (init)         next_state = ST_INIT;
            else if (any_err) next_state = ST_ERROR;
            else              next_state = ST_IDLE;
         end
         ST_IDLE: begin
            if (init)            next_state = ST_INIT;
            else if (any_err)    next_state = ST_ERROR;
            else if (!all_empty) next_state = ST_ACTIVE;
            else                 next_state = ST_IDLE;
         end
         ST_ACTIVE: begin
            if (init)           next_state = ST_INIT;
            else if (any_err)   next_state = ST_ERROR;
            else if (all_empty) next_state = ST_IDLE;
            else                next_state = ST_ACTIVE;
         end
         ST_ERROR: begin
            if (init)                       next_state = ST_INIT;
            else if (err_clear && !any_err) next_state = ST_IDLE;
            else                            next_state = ST_ERROR;
         end
         default: next_state = ST_RESET;
      endcase
   end

   // State register and all registered outputs; error flags are only ever non-zero in ERROR.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= ST_RESET;
         idle_out     <= 1'b0;
         active_out   <= 1'b0;
         umbrales_out <= '0;
         error_out    <= '0;
         error_cnt    <= '0;
      end else begin
         state      <= next_state;
         idle_out   <= (next_state == ST_IDLE);
         active_out <= (next_state == ST_ACTIVE);

         if ((state == ST_INIT) || (state == ST_ERROR)) begin
            umbrales_out <= umbral_in;
         end else begin
            umbrales_out <= umbrales_out;
         end

         if (next_state == ST_ERROR) begin
            if (state == ST_ERROR) begin
               error_out <= error_out | fifo_error;
            end else begin
               error_out <= fifo_error;
            end
         end else begin
            error_out <= '0;
         end

         if ((next_state == ST_ERROR) && (state != ST_ERROR) && (error_cnt != CNT_MAX)) begin
            error_cnt <= error_cnt + CNT_W'(1);
         end else begin
            error_cnt <= error_cnt;
         end
      end
   end

endmodule
